fun_fpsu_vcmp: RTL and testbench

Parametrised packed single-precision compare/logic/permute unit for the FP backend. It is the next-generation sibling of the fixed two-lane FP simple unit. Lane count and pipeline depth are generic. It adds sticky exception-flag accumulation and pipeline flush. It takes operands after forwarding resolution and produces a lane-wide result plus a masked exception retire code.

---
 rtl/fpsu_pkg.sv | 33 +++
 rtl/fpsu_vcmp_lane.sv | 65 ++++++
 rtl/fun_fpsu_vcmp.sv | 204 ++++++++++++++++++++
 tb/tb_fun_fpsu_vcmp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpsu_pkg.sv
// Shared constants for the packed single-precision compare/logic/permute unit:
// op codes, flag bit positions, retire-code field layout and lane width.
package fpsu_pkg;

    localparam int LANE_W       = 32;
    localparam int FLAG_W       = 11;
    localparam int RET_W        = 14;
    localparam int RET_CODE_LSB = 0;
    localparam int RET_LANE_LSB = 11;
    localparam int RET_LANE_W   = 3;

    localparam int FLG_INV = 0;
    localparam int FLG_DEN = 1;

    localparam logic [3:0] OP_CMP_EQ    = 4'd0;
    localparam logic [3:0] OP_CMP_LT    = 4'd1;
    localparam logic [3:0] OP_CMP_LE    = 4'd2;
    localparam logic [3:0] OP_CMP_UNORD = 4'd3;
    localparam logic [3:0] OP_AND       = 4'd4;
    localparam logic [3:0] OP_OR        = 4'd5;
    localparam logic [3:0] OP_XOR       = 4'd6;
    localparam logic [3:0] OP_ANDN      = 4'd7;
    localparam logic [3:0] OP_SWAP      = 4'd8;
    localparam logic [3:0] OP_DUP       = 4'd9;
    localparam logic [3:0] OP_MIN       = 4'd10;
    localparam logic [3:0] OP_MAX       = 4'd11;

    // Expand a compare outcome into an all-ones / all-zeros lane mask.
    function automatic logic [LANE_W-1:0] lane_fill(input logic b);
        return {LANE_W{b}};
    endfunction

endpackage

// File: rtl/fpsu_vcmp_lane.sv
// Single-lane combinational classify/compare for binary32 operands.
// min/max outputs exist only when FPSU_MINMAX_EN is defined.
module fpsu_vcmp_lane
    import fpsu_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    output logic              o_eq,
    output logic              o_lt,
    output logic              o_le,
    output logic              o_unord,
    output logic              o_nan_any,
    output logic              o_snan_any,
`ifdef FPSU_MINMAX_EN
    output logic [LANE_W-1:0] o_min,
    output logic [LANE_W-1:0] o_max,
`endif
    output logic              o_den_any
);

    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic w_a_den, w_b_den, w_a_zero, w_b_zero;
    logic w_both_zero, w_nan_any, w_eq, w_lt_raw, w_lt;

    assign w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    assign w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    assign w_a_snan = w_a_nan && !i_a[22];
    assign w_b_snan = w_b_nan && !i_b[22];
    assign w_a_den  = (i_a[30:23] == 8'h00) && (i_a[22:0] != 23'd0);
    assign w_b_den  = (i_b[30:23] == 8'h00) && (i_b[22:0] != 23'd0);
    assign w_a_zero = (i_a[30:0] == 31'd0);
    assign w_b_zero = (i_b[30:0] == 31'd0);

    assign w_both_zero = w_a_zero && w_b_zero;
    assign w_nan_any   = w_a_nan || w_b_nan;

    // Sign-magnitude ordering: negative magnitudes compare reversed.
    always_comb begin
        if (i_a[31] != i_b[31]) begin
            w_lt_raw = i_a[31] && !w_both_zero;
        end else if (!i_a[31]) begin
            w_lt_raw = i_a[30:0] < i_b[30:0];
        end else begin
            w_lt_raw = i_a[30:0] > i_b[30:0];
        end
    end

    assign w_eq = !w_nan_any && ((i_a == i_b) || w_both_zero);
    assign w_lt = !w_nan_any && w_lt_raw;

    assign o_eq       = w_eq;
    assign o_lt       = w_lt;
    assign o_le       = w_lt || w_eq;
    assign o_unord    = w_nan_any;
    assign o_nan_any  = w_nan_any;
    assign o_snan_any = w_a_snan || w_b_snan;
    assign o_den_any  = w_a_den || w_b_den;

`ifdef FPSU_MINMAX_EN
    // Any NaN returns B; w_lt is already false in that case.
    assign o_min = w_lt ? i_a : i_b;
    assign o_max = (w_nan_any || w_lt) ? i_b : i_a;
`endif

endmodule

// File: rtl/fun_fpsu_vcmp.sv
// Packed binary32 compare/logic/permute unit with DEPTH-cycle pipeline, flush,
// sticky flags and masked retire code. Define FPSU_MINMAX_EN to enable min/max.
module fun_fpsu_vcmp
    import fpsu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 2
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_en,
    input  logic [3:0]              in_op,
    input  logic                    in_ord,
    input  logic [LANE_W*LANES-1:0] in_A,
    input  logic [LANE_W*LANES-1:0] in_B,
    input  logic [FLAG_W-1:0]       fpcsr_mask,
    input  logic                    flush,
    input  logic                    clr_flags,
    output logic                    out_en,
    output logic [LANE_W*LANES-1:0] out_res,
    output logic [RET_W-1:0]        ret,
    output logic                    ret_en,
    output logic [FLAG_W-1:0]       flags
);

    localparam int W = LANE_W * LANES;

    // Issue register: captures operands at the issue edge.
    logic              r_s0_valid;
    logic [3:0]        r_s0_op;
    logic              r_s0_ord;
    logic [W-1:0]      r_s0_a;
    logic [W-1:0]      r_s0_b;
    logic [FLAG_W-1:0] r_s0_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
        end else begin
            r_s0_valid <= in_en;
        end
        if (in_en) begin
            r_s0_op   <= in_op;
            r_s0_ord  <= in_ord;
            r_s0_a    <= in_A;
            r_s0_b    <= in_B;
            r_s0_mask <= fpcsr_mask;
        end
    end

    logic [LANES-1:0] w_eq, w_lt, w_le, w_unord, w_nan, w_snan, w_den;
`ifdef FPSU_MINMAX_EN
    logic [LANES-1:0][LANE_W-1:0] w_min, w_max;
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            fpsu_vcmp_lane u_lane (
                .i_a        (r_s0_a[gi*LANE_W +: LANE_W]),
                .i_b        (r_s0_b[gi*LANE_W +: LANE_W]),
                .o_eq       (w_eq[gi]),
                .o_lt       (w_lt[gi]),
                .o_le       (w_le[gi]),
                .o_unord    (w_unord[gi]),
                .o_nan_any  (w_nan[gi]),
                .o_snan_any (w_snan[gi]),
`ifdef FPSU_MINMAX_EN
                .o_min      (w_min[gi]),
                .o_max      (w_max[gi]),
`endif
                .o_den_any  (w_den[gi])
            );
        end
    endgenerate

    logic [W-1:0]      w_res;
    logic [FLAG_W-1:0] w_raise;
    logic [RET_W-1:0]  w_ret;

    always_comb begin
        logic [LANE_W-1:0]     v_a;
        logic [LANE_W-1:0]     v_b;
        logic [LANE_W-1:0]     v_r;
        logic [FLAG_W-1:0]     v_lr;
        logic                  v_found;
        logic [RET_LANE_W-1:0] v_lane;
        w_res   = '0;
        w_raise = '0;
        w_ret   = '0;
        v_found = 1'b0;
        v_lane  = '0;
        for (int i = 0; i < LANES; i++) begin
            v_a  = r_s0_a[i*LANE_W +: LANE_W];
            v_b  = r_s0_b[i*LANE_W +: LANE_W];
            v_r  = '0;
            v_lr = '0;
            case (r_s0_op)
                OP_CMP_EQ: begin
                    v_r           = lane_fill(w_eq[i]);
                    v_lr[FLG_INV] = w_snan[i];
                    v_lr[FLG_DEN] = w_den[i];
                end
                OP_CMP_LT: begin
                    v_r           = lane_fill(w_lt[i]);
                    v_lr[FLG_INV] = w_snan[i] | (r_s0_ord & w_nan[i]);
                    v_lr[FLG_DEN] = w_den[i];
                end
                OP_CMP_LE: begin
                    v_r           = lane_fill(w_le[i]);
                    v_lr[FLG_INV] = w_snan[i] | (r_s0_ord & w_nan[i]);
                    v_lr[FLG_DEN] = w_den[i];
                end
                OP_CMP_UNORD: begin
                    v_r           = lane_fill(w_unord[i]);
                    v_lr[FLG_INV] = w_snan[i];
                    v_lr[FLG_DEN] = w_den[i];
                end
                OP_AND:  v_r = v_a & v_b;
                OP_OR:   v_r = v_a | v_b;
                OP_XOR:  v_r = v_a ^ v_b;
                OP_ANDN: v_r = ~v_a & v_b;
                // Lane pairs (2k, 2k+1): swap partners, or broadcast the even lane.
                OP_SWAP: v_r = r_s0_a[(i ^ 1)*LANE_W +: LANE_W];
                OP_DUP:  v_r = r_s0_a[(i & ~1)*LANE_W +: LANE_W];
`ifdef FPSU_MINMAX_EN
                OP_MIN: begin
                    v_r           = w_min[i];
                    v_lr[FLG_INV] = w_snan[i];
                    v_lr[FLG_DEN] = w_den[i];
                end
                OP_MAX: begin
                    v_r           = w_max[i];
                    v_lr[FLG_INV] = w_snan[i];
                    v_lr[FLG_DEN] = w_den[i];
                end
`endif
                default: v_r = '0;
            endcase
            w_res[i*LANE_W +: LANE_W] = v_r;
            w_raise = w_raise | v_lr;
            if (!v_found && (|(v_lr & r_s0_mask))) begin
                v_found = 1'b1;
                v_lane  = RET_LANE_W'(i);
            end
        end
        w_ret[RET_CODE_LSB +: FLAG_W]     = w_raise & r_s0_mask;
        w_ret[RET_LANE_LSB +: RET_LANE_W] = v_lane;
    end

    // Result stages 1..DEPTH; flush drops every valid older than the issue edge.
    logic              r_valid [1:DEPTH];
    logic [W-1:0]      r_res   [1:DEPTH];
    logic [FLAG_W-1:0] r_raise [1:DEPTH];
    logic [RET_W-1:0]  r_ret   [1:DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else begin
            r_valid[1] <= r_s0_valid & ~flush;
            for (int k = 2; k <= DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1] & ~flush;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_res[1]   <= w_res;
        r_raise[1] <= w_raise;
        r_ret[1]   <= w_ret;
        for (int k = 2; k <= DEPTH; k++) begin
            r_res[k]   <= r_res[k-1];
            r_raise[k] <= r_raise[k-1];
            r_ret[k]   <= r_ret[k-1];
        end
    end

    logic              w_out_valid;
    logic              w_ret_en;
    logic [FLAG_W-1:0] r_flags;

    assign w_out_valid = r_valid[DEPTH];
    assign w_ret_en    = w_out_valid & (|r_ret[DEPTH][RET_CODE_LSB +: FLAG_W]);

    assign out_en  = w_out_valid;
    assign out_res = w_out_valid ? r_res[DEPTH] : '0;
    assign ret_en  = w_ret_en;
    assign ret     = w_ret_en ? r_ret[DEPTH] : '0;

    // Clear takes effect first so a same-cycle completion still sets its bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= (clr_flags ? '0 : r_flags) | (w_out_valid ? r_raise[DEPTH] : '0);
        end
    end

    assign flags = r_flags;

endmodule

// File: tb/tb_fun_fpsu_vcmp.sv
// Scoreboard bench for fun_fpsu_vcmp (LANES=4, DEPTH=2): stimulus pushes expected
// results, a negedge monitor pops and compares whenever out_en is seen.
module tb_fun_fpsu_vcmp;

    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int W     = 32 * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_en = 1'b0;
    logic [3:0]    in_op = '0;
    logic          in_ord = 1'b0;
    logic [W-1:0]  in_A = '0;
    logic [W-1:0]  in_B = '0;
    logic [10:0]   fpcsr_mask = '0;
    logic          flush = 1'b0;
    logic          clr_flags = 1'b0;
    logic          out_en;
    logic [W-1:0]  out_res;
    logic [13:0]   ret;
    logic          ret_en;
    logic [10:0]   flags;

    always #5 clk = ~clk;

    fun_fpsu_vcmp #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .in_op      (in_op),
        .in_ord     (in_ord),
        .in_A       (in_A),
        .in_B       (in_B),
        .fpcsr_mask (fpcsr_mask),
        .flush      (flush),
        .clr_flags  (clr_flags),
        .out_en     (out_en),
        .out_res    (out_res),
        .ret        (ret),
        .ret_en     (ret_en),
        .flags      (flags)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         ret_en;
        logic [13:0]  ret;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] v4(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push(input logic [W-1:0] res, input logic r_en, input logic [13:0] r);
        exp_t e;
        e.res    = res;
        e.ret_en = r_en;
        e.ret    = r;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic ord, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [10:0] mask, input logic fl);
        @(negedge clk);
        in_en      = 1'b1;
        in_op      = op;
        in_ord     = ord;
        in_A       = a;
        in_B       = b;
        fpcsr_mask = mask;
        flush      = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_en     = 1'b0;
            flush     = 1'b0;
            clr_flags = 1'b0;
        end
    endtask

    task automatic clear_flags();
        @(negedge clk);
        in_en     = 1'b0;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    // Monitor: one line per completed op, gated-zero check when idle.
    always @(negedge clk) begin
        exp_t e;
        if (out_en) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_en: got res %h, required no output", out_res);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] result res=%h ret_en=%0b ret=%h", out_res, ret_en, ret);
                chk("out_res", out_res, e.res);
                chk("ret_en", W'(ret_en), W'(e.ret_en));
                chk("ret", W'(ret), W'(e.ret));
            end
        end else begin
            chk("idle_res", out_res, '0);
            chk("idle_ret", W'({ret_en, ret}), '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] THR  = 32'h40400000;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] SNAN = 32'h7F800001;
    localparam logic [31:0] NZ   = 32'h80000000;
    localparam logic [31:0] ONES = 32'hFFFFFFFF;

    initial begin
        logic [W-1:0] mm_a, mm_b, min_exp, max_exp;

        repeat (3) @(negedge clk);
        chk("reset_flags", W'(flags), '0);
        chk("reset_out_en", W'(out_en), '0);
        rst = 1'b0;

        // cmp_lt, unordered: only lane 0 true
        issue(4'd1, 1'b0, v4(NZ, QNAN, TWO, ONE), v4(32'h0, ONE, ONE, TWO), 11'h000, 1'b0);
        push(v4(0, 0, 0, ONES), 1'b0, 14'h0);
        idle(4);
        chk("lt_flags", W'(flags), '0);

        // cmp_lt ordered: qNaN in lane 2 raises invalid, unmasked
        issue(4'd1, 1'b1, v4(NZ, QNAN, TWO, ONE), v4(32'h0, ONE, ONE, TWO), 11'h001, 1'b0);
        push(v4(0, 0, 0, ONES), 1'b1, 14'h1001);
        idle(4);
        chk("lt_ord_flags", W'(flags), W'(11'h001));
        clear_flags();
        chk("clr_flags", W'(flags), '0);

        // cmp_eq with sNaN in lane 0, masked off: sticky flag only
        issue(4'd0, 1'b0, v4(ONE, ONE, ONE, SNAN), v4(ONE, ONE, ONE, ONE), 11'h000, 1'b0);
        push(v4(ONES, ONES, ONES, 0), 1'b0, 14'h0);
        idle(4);
        chk("snan_flags", W'(flags), W'(11'h001));
        clear_flags();
        chk("snan_clr", W'(flags), '0);

        // denormal operand in lane 0, denormal enabled
        issue(4'd0, 1'b0, v4(ONE, ONE, ONE, 32'h00000001), v4(ONE, ONE, ONE, 32'h0), 11'h002, 1'b0);
        push(v4(ONES, ONES, ONES, 0), 1'b1, 14'h0002);
        idle(4);
        chk("den_flags", W'(flags), W'(11'h002));

        // sNaN completion in the same cycle as clr_flags: old den bit cleared, inv set
        issue(4'd0, 1'b0, v4(ONE, ONE, ONE, SNAN), v4(ONE, ONE, ONE, ONE), 11'h000, 1'b0);
        push(v4(ONES, ONES, ONES, 0), 1'b0, 14'h0);
        idle(2);
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("clr_and_set", W'(flags), W'(11'h001));
        clear_flags();

        // cmp_unord: sNaN in lane 1 gives lowest masked lane 1
        issue(4'd3, 1'b0, v4(QNAN, ONE, SNAN, ONE), v4(ONE, ONE, ONE, QNAN), 11'h003, 1'b0);
        push(v4(ONES, 0, ONES, ONES), 1'b1, 14'h0801);
        // cmp_le including both-negative and signed zeros
        issue(4'd2, 1'b0, v4(32'hC0000000, THR, ONE, 32'h0), v4(32'hBF800000, TWO, TWO, NZ), 11'h003, 1'b0);
        push(v4(ONES, 0, ONES, ONES), 1'b0, 14'h0);
        idle(4);
        chk("unord_flags", W'(flags), W'(11'h001));
        clear_flags();

        // bitwise ops back to back; sNaN in B must not raise
        issue(4'd4, 1'b0, v4(32'hF0F0F0F0, 32'h12345678, ONES, 32'h0), v4(32'h0FF00FF0, 32'h87654321, SNAN, 32'hAAAAAAAA), 11'h003, 1'b0);
        push(v4(32'h00F000F0, 32'h02244220, SNAN, 32'h0), 1'b0, 14'h0);
        issue(4'd5, 1'b0, v4(32'hF0F0F0F0, 32'h12345678, ONES, 32'h0), v4(32'h0FF00FF0, 32'h87654321, SNAN, 32'hAAAAAAAA), 11'h003, 1'b0);
        push(v4(32'hFFF0FFF0, 32'h97755779, ONES, 32'hAAAAAAAA), 1'b0, 14'h0);
        issue(4'd6, 1'b0, v4(32'hF0F0F0F0, 32'h12345678, ONES, 32'h0), v4(32'h0FF00FF0, 32'h87654321, SNAN, 32'hAAAAAAAA), 11'h003, 1'b0);
        push(v4(32'hFF00FF00, 32'h95511559, 32'h807FFFFE, 32'hAAAAAAAA), 1'b0, 14'h0);
        issue(4'd7, 1'b0, v4(32'hF0F0F0F0, 32'h12345678, ONES, 32'h0), v4(32'h0FF00FF0, 32'h87654321, SNAN, 32'hAAAAAAAA), 11'h003, 1'b0);
        push(v4(32'h0F000F00, 32'h85410101, 32'h0, 32'hAAAAAAAA), 1'b0, 14'h0);
        // permutes
        issue(4'd8, 1'b0, v4(32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111), '0, 11'h003, 1'b0);
        push(v4(32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222), 1'b0, 14'h0);
        issue(4'd9, 1'b0, v4(32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111), '0, 11'h003, 1'b0);
        push(v4(32'h33333333, 32'h33333333, 32'h11111111, 32'h11111111), 1'b0, 14'h0);
        idle(4);
        chk("logic_flags", W'(flags), '0);

        // min/max (config dependent) and an illegal op carrying sNaN
        mm_a = v4(32'h40A00000, 32'hC0000000, ONE, QNAN);
        mm_b = v4(32'hBF800000, ONE, TWO, THR);
`ifdef FPSU_MINMAX_EN
        min_exp = v4(32'hBF800000, 32'hC0000000, ONE, THR);
        max_exp = v4(32'h40A00000, ONE, TWO, THR);
`else
        min_exp = '0;
        max_exp = '0;
`endif
        issue(4'd10, 1'b0, mm_a, mm_b, 11'h003, 1'b0);
        push(min_exp, 1'b0, 14'h0);
        issue(4'd11, 1'b0, mm_a, mm_b, 11'h003, 1'b0);
        push(max_exp, 1'b0, 14'h0);
        issue(4'd14, 1'b0, v4(SNAN, SNAN, SNAN, SNAN), v4(SNAN, SNAN, SNAN, SNAN), 11'h003, 1'b0);
        push('0, 1'b0, 14'h0);
        idle(4);
        chk("illegal_flags", W'(flags), '0);

        // flush on third issue: only ops 3 and 4 complete
        issue(4'd4, 1'b0, v4(32'h11111111, 0, 0, 1), v4(ONES, ONES, ONES, ONES), 11'h000, 1'b0);
        issue(4'd4, 1'b0, v4(32'h22222222, 0, 0, 2), v4(ONES, ONES, ONES, ONES), 11'h000, 1'b0);
        issue(4'd4, 1'b0, v4(32'h33333333, 0, 0, 3), v4(ONES, ONES, ONES, ONES), 11'h000, 1'b1);
        push(v4(32'h33333333, 0, 0, 3), 1'b0, 14'h0);
        issue(4'd4, 1'b0, v4(32'h44444444, 0, 0, 4), v4(ONES, ONES, ONES, ONES), 11'h000, 1'b0);
        push(v4(32'h44444444, 0, 0, 4), 1'b0, 14'h0);
        idle(4);
        chk("flush_drained", W'(sb_q.size()), '0);

        // set a sticky flag, then reset with two ops in flight
        issue(4'd0, 1'b0, v4(ONE, ONE, ONE, SNAN), v4(ONE, ONE, ONE, ONE), 11'h000, 1'b0);
        push(v4(ONES, ONES, ONES, 0), 1'b0, 14'h0);
        idle(4);
        chk("pre_reset_flags", W'(flags), W'(11'h001));
        issue(4'd4, 1'b0, v4(ONES, ONES, ONES, ONES), v4(ONES, ONES, ONES, ONES), 11'h003, 1'b0);
        issue(4'd0, 1'b0, v4(ONE, ONE, ONE, SNAN), v4(ONE, ONE, ONE, ONE), 11'h003, 1'b0);
        @(negedge clk);
        in_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("post_reset_flags", W'(flags), '0);
        chk("post_reset_out_en", W'(out_en), '0);
        chk("post_reset_res", out_res, '0);
        chk("post_reset_ret", W'({ret_en, ret}), '0);
        chk("sb_empty", W'(sb_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
